// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl: multi-cycle sequencer for the stack datapath.
//   Accepts one instruction per valid/ready handshake and expands it into per-cycle
//   push/pop strobes, operand latch enables and an ALU op. Tracks stack depth and
//   rejects overflow, underflow and illegal opcodes with a one-cycle fault pulse.
// Ports:
//   clock_i         clock, rising edge
//   reset_i         synchronous active-high reset
//   instr_valid_i   instruction present on instr_i
//   instr_i         opcode in MSBs, immediate in the remaining LSBs
//   instr_ready_o   high only while idle
//   push_o, pop_o   stack write / read strobes
//   sel_imm_o       push data mux: 1 = immediate, 0 = ALU result
//   imm_o           zero-extended immediate of the last accepted instruction
//   latch_a_o       capture popped top into operand A
//   latch_b_o       capture popped entry into operand B
//   alu_op_o        ALU function during write-back, else 0
//   depth_o         current stack entry count
//   busy_o          sequencer not idle
//   fault_o         one-cycle pulse on a rejected instruction
//   fault_code_o    last fault cause: 1 overflow, 2 underflow, 3 illegal
module stack_seq_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OPC_W  = 6,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                              clock_i,
    input  logic                              reset_i,
    input  logic                              instr_valid_i,
    input  logic [DATA_W-1:0]                 instr_i,
    output logic                              instr_ready_o,
    output logic                              push_o,
    output logic                              pop_o,
    output logic                              sel_imm_o,
    output logic [DATA_W-1:0]                 imm_o,
    output logic                              latch_a_o,
    output logic                              latch_b_o,
    output logic [3:0]                        alu_op_o,
    output logic [$clog2(DEPTH+1)-1:0]        depth_o,
    output logic                              busy_o,
    output logic                              fault_o,
    output logic [1:0]                        fault_code_o
);
    localparam int unsigned DPT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {StIdle, StPushI, StPop1, StPopA, StPopB, StWb, StFlt} state_e;

    state_e             state_q, state_d;
    logic [DPT_W-1:0]   depth_q, depth_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [3:0]         alu_sel_q, alu_sel_d;
    logic [1:0]         fault_code_q, fault_code_d;
    logic               ready_q, push_q, pop_q, sel_imm_q, latch_a_q, latch_b_q;
    logic               busy_q, fault_q;
    logic [3:0]         alu_op_q;
    logic               ready_d, push_d, pop_d, sel_imm_d, latch_a_d, latch_b_d;
    logic               busy_d, fault_d;
    logic [3:0]         alu_op_d;

    logic               accept;
    logic [OPC_W-1:0]   opcode;

    assign accept = instr_valid_i & ready_q;
    assign opcode = instr_i[DATA_W-1 -: OPC_W];

    // State register plus registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            depth_q      <= '0;
            imm_q        <= '0;
            alu_sel_q    <= '0;
            fault_code_q <= '0;
            ready_q      <= 1'b1;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            sel_imm_q    <= 1'b0;
            latch_a_q    <= 1'b0;
            latch_b_q    <= 1'b0;
            alu_op_q     <= '0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            imm_q        <= imm_d;
            alu_sel_q    <= alu_sel_d;
            fault_code_q <= fault_code_d;
            ready_q      <= ready_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            sel_imm_q    <= sel_imm_d;
            latch_a_q    <= latch_a_d;
            latch_b_q    <= latch_b_d;
            alu_op_q     <= alu_op_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    // Next-state: accept checks use the depth present in the accept cycle.
    always_comb begin
        state_d      = state_q;
        imm_d        = imm_q;
        alu_sel_d    = alu_sel_q;
        fault_code_d = fault_code_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    imm_d = {{OPC_W{1'b0}}, instr_i[DATA_W-OPC_W-1:0]};
                    case (opcode)
                        OPC_W'(1): begin
                            if (depth_q == DPT_W'(DEPTH)) begin
                                state_d      = StFlt;
                                fault_code_d = 2'd1;
                            end else begin
                                state_d = StPushI;
                            end
                        end
                        OPC_W'(2): begin
                            if (depth_q == '0) begin
                                state_d      = StFlt;
                                fault_code_d = 2'd2;
                            end else begin
                                state_d = StPop1;
                            end
                        end
                        OPC_W'(3), OPC_W'(4), OPC_W'(5), OPC_W'(6), OPC_W'(7): begin
                            if (depth_q < DPT_W'(2)) begin
                                state_d      = StFlt;
                                fault_code_d = 2'd2;
                            end else begin
                                state_d = StPopA;
                                case (opcode)
                                    OPC_W'(3): alu_sel_d = 4'd2;
                                    OPC_W'(4): alu_sel_d = 4'd1;
                                    OPC_W'(5): alu_sel_d = 4'd6;
                                    OPC_W'(6): alu_sel_d = 4'd7;
                                    default:   alu_sel_d = 4'd12;
                                endcase
                            end
                        end
                        default: begin
                            state_d      = StFlt;
                            fault_code_d = 2'd3;
                        end
                    endcase
                end
            end
            StPopA:  state_d = StPopB;
            StPopB:  state_d = StWb;
            default: state_d = StIdle;
        endcase
    end

    // Depth follows the strobes once they have been issued.
    always_comb begin
        depth_d = depth_q;
        if (push_q) begin
            depth_d = depth_q + DPT_W'(1);
        end else if (pop_q) begin
            depth_d = depth_q - DPT_W'(1);
        end
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        ready_d   = (state_d == StIdle);
        busy_d    = (state_d != StIdle);
        push_d    = (state_d == StPushI) || (state_d == StWb);
        pop_d     = (state_d == StPop1) || (state_d == StPopA) || (state_d == StPopB);
        sel_imm_d = (state_d == StPushI);
        latch_a_d = (state_d == StPopA);
        latch_b_d = (state_d == StPopB);
        alu_op_d  = (state_d == StWb) ? alu_sel_q : 4'd0;
        fault_d   = (state_d == StFlt);
    end

    assign instr_ready_o = ready_q;
    assign push_o        = push_q;
    assign pop_o         = pop_q;
    assign sel_imm_o     = sel_imm_q;
    assign imm_o         = imm_q;
    assign latch_a_o     = latch_a_q;
    assign latch_b_o     = latch_b_q;
    assign alu_op_o      = alu_op_q;
    assign depth_o       = depth_q;
    assign busy_o        = busy_q;
    assign fault_o       = fault_q;
    assign fault_code_o  = fault_code_q;
endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Testbench for stack_seq_ctrl with a small stack so overflow is easy to reach.
module tb_stack_seq_ctrl;
    localparam int DATA_W = 32;
    localparam int OPC_W  = 6;
    localparam int DEPTH  = 4;
    localparam int DPT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              instr_ready, push, pop, sel_imm, latch_a, latch_b, busy, fault;
    logic [DATA_W-1:0] imm;
    logic [3:0]        alu_op;
    logic [DPT_W-1:0]  depth;
    logic [1:0]        fault_code;

    int total = 0;
    int bad   = 0;
    int md    = 0;          // model stack depth
    logic [1:0] mcode = 2'd0;  // model fault code

    stack_seq_ctrl #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH)) dut (
        .clock_i(clk), .reset_i(reset), .instr_valid_i(instr_valid), .instr_i(instr),
        .instr_ready_o(instr_ready), .push_o(push), .pop_o(pop), .sel_imm_o(sel_imm),
        .imm_o(imm), .latch_a_o(latch_a), .latch_b_o(latch_b), .alu_op_o(alu_op),
        .depth_o(depth), .busy_o(busy), .fault_o(fault), .fault_code_o(fault_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (push && pop) begin
                bad++;
                $display("FAIL push_pop_overlap: push=%b pop=%b required not both 1", push, pop);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] alu_of(input int opc);
        case (opc)
            3: return 4'd2;
            4: return 4'd1;
            5: return 4'd6;
            6: return 4'd7;
            7: return 4'd12;
            default: return 4'd0;
        endcase
    endfunction

    // Observed vector: push pop sel la lb alu[4] fault busy ready
    function automatic logic [11:0] mk(input bit p, input bit q, input bit s, input bit a,
                                       input bit b, input logic [3:0] op, input bit f);
        return {p, q, s, a, b, op, f, 1'b1, 1'b0};
    endfunction

    // Issue one instruction from an idle negedge and score every cycle of its expansion.
    task automatic run_instr(input logic [31:0] ins);
        logic [11:0] seq[$];
        logic [11:0] obs;
        logic [31:0] eimm;
        int opc;
        opc  = int'(ins[31:26]);
        eimm = {6'b0, ins[25:0]};
        if (opc == 1) begin
            if (md == DEPTH) begin seq.push_back(mk(0, 0, 0, 0, 0, 0, 1)); mcode = 2'd1; end
            else seq.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        end else if (opc == 2) begin
            if (md == 0) begin seq.push_back(mk(0, 0, 0, 0, 0, 0, 1)); mcode = 2'd2; end
            else seq.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        end else if (opc >= 3 && opc <= 7) begin
            if (md < 2) begin seq.push_back(mk(0, 0, 0, 0, 0, 0, 1)); mcode = 2'd2; end
            else begin
                seq.push_back(mk(0, 1, 0, 1, 0, 0, 0));
                seq.push_back(mk(0, 1, 0, 0, 1, 0, 0));
                seq.push_back(mk(1, 0, 0, 0, 0, alu_of(opc), 0));
            end
        end else begin
            seq.push_back(mk(0, 0, 0, 0, 0, 0, 1));
            mcode = 2'd3;
        end
        total++;
        if (instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_accept: got %b required 1", instr_ready);
        end
        instr_valid = 1'b1;
        instr       = ins;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = $urandom;
        foreach (seq[i]) begin
            obs = {push, pop, sel_imm, latch_a, latch_b, alu_op, fault, busy, instr_ready};
            total++;
            if (obs !== seq[i]) begin
                bad++;
                $display("FAIL strobes ins=%h cyc=%0d: got %b required %b", ins, i, obs, seq[i]);
            end
            total++;
            if (depth !== DPT_W'(md)) begin
                bad++;
                $display("FAIL depth ins=%h cyc=%0d: got %0d required %0d", ins, i, depth, md);
            end
            if (i == 0) begin
                total++;
                if (imm !== eimm) begin
                    bad++;
                    $display("FAIL imm ins=%h: got %h required %h", ins, imm, eimm);
                end
                total++;
                if (fault_code !== mcode) begin
                    bad++;
                    $display("FAIL fault_code ins=%h: got %0d required %0d", ins, fault_code, mcode);
                end
            end
            md = md + int'(seq[i][11]) - int'(seq[i][10]);
            @(negedge clk);
        end
        total++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || depth !== DPT_W'(md)) begin
            bad++;
            $display("FAIL idle_after ins=%h: ready=%b busy=%b depth=%0d required 1 0 %0d",
                     ins, instr_ready, busy, depth, md);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++;
        if ({push, pop, sel_imm, latch_a, latch_b, alu_op, fault, busy} !== 11'd0 ||
            instr_ready !== 1'b1 || depth !== '0 || imm !== '0 || fault_code !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: push=%b pop=%b alu=%0d fault=%b busy=%b rdy=%b depth=%0d imm=%h code=%0d required all zero, rdy=1",
                     push, pop, alu_op, fault, busy, instr_ready, depth, imm, fault_code);
        end
        md = 0;
        mcode = 2'd0;
    endtask

    task automatic test_push();
        run_instr(32'h0400_0005);
    endtask

    task automatic test_add();
        run_instr(32'h0400_0003);
        run_instr(32'h0400_0004);
        run_instr(32'h0C00_0000);
    endtask

    task automatic test_overflow();
        while (md < DEPTH) run_instr(32'h0400_0000 | 32'($urandom_range(0, 1000)));
        run_instr(32'h0400_0077);
        total++;
        if (depth !== DPT_W'(DEPTH)) begin
            bad++;
            $display("FAIL overflow_depth: got %0d required %0d", depth, DEPTH);
        end
    endtask

    task automatic test_underflow_illegal();
        while (md > 1) run_instr(32'h0800_0000);
        run_instr(32'h1400_0000);
        run_instr(32'hFC00_0000);
        run_instr(32'h0000_0000);
    endtask

    task automatic test_reset_mid();
        run_instr(32'hFC00_0001);  // leave a nonzero fault code behind
        while (md < 2) run_instr(32'h0400_0009);
        instr_valid = 1'b1;
        instr = 32'h0C00_0000;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        total++;
        if (pop !== 1'b1 || latch_b !== 1'b1) begin
            bad++;
            $display("FAIL pop_b_phase: pop=%b latch_b=%b required 1 1", pop, latch_b);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({push, pop, latch_a, latch_b, alu_op} !== 8'd0 || depth !== '0 ||
            instr_ready !== 1'b1 || fault_code !== 2'd0) begin
            bad++;
            $display("FAIL reset_mid: push=%b pop=%b alu=%0d depth=%0d rdy=%b code=%0d required 0 0 0 0 1 0",
                     push, pop, alu_op, depth, instr_ready, fault_code);
        end
        @(negedge clk);
        total++;
        if (push !== 1'b0 || pop !== 1'b0) begin
            bad++;
            $display("FAIL after_reset_strobes: push=%b pop=%b required 0 0", push, pop);
        end
        md = 0;
        mcode = 2'd0;
    endtask

    task automatic test_back_to_back();
        int acc;
        acc = 0;
        while (md < 3) run_instr(32'h0400_0011);
        instr_valid = 1'b1;
        instr = 32'h0C00_0000;
        for (int k = 0; k < 8; k++) begin
            if (instr_valid && instr_ready) acc++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        md = md - 2;
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL held_valid_accepts: got %0d required 2", acc);
        end
        total++;
        if (depth !== DPT_W'(md) || instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL held_valid_depth: depth=%0d rdy=%b required %0d 1", depth, instr_ready, md);
        end
    endtask

    task automatic test_random();
        logic [5:0] opc;
        int r;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      opc = 6'd1;
            else if (r == 3) opc = 6'd2;
            else if (r <= 7) opc = 6'($urandom_range(3, 7));
            else if (r == 8) opc = 6'd0;
            else             opc = 6'($urandom_range(8, 63));
            run_instr({opc, 26'($urandom)});
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_add();
        test_overflow();
        test_underflow_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
